// File: rtl/mult_pipe_hs.sv
// Pipelined A x B multiplier with per-operand signedness and a valid/ready handshake on both sides.
// Optional macro MULT_APPROX_TRUNC_EN clears the TRUNC_BITS LSBs of A for transactions flagged i_approx.
module mult_pipe_hs #(
  parameter int A_W        = 8,
  parameter int B_W        = 8,
  parameter int LAT        = 2,
  parameter int TRUNC_BITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [A_W-1:0]       i_a,
  input  logic [B_W-1:0]       i_b,
  input  logic                 i_a_signed,
  input  logic                 i_b_signed,
  input  logic                 i_approx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [A_W+B_W:0]     o_mult
);

  localparam int P_W = A_W + B_W + 1;

  logic                 adv;
  logic [LAT-1:0]       vld_q, vld_d;
  logic [P_W-1:0]       dat_q [LAT];
  logic [P_W-1:0]       dat_d [LAT];

  logic [A_W-1:0]       a_eff;
  logic signed [A_W:0]  a_ext;
  logic signed [B_W:0]  b_ext;
  logic signed [P_W-1:0] prod;

`ifdef MULT_APPROX_TRUNC_EN
  localparam logic [A_W-1:0] TRUNC_MASK = {A_W{1'b1}} << TRUNC_BITS;
  assign a_eff = i_approx ? (i_a & TRUNC_MASK) : i_a;
`else
  logic unused_approx;
  assign unused_approx = i_approx & (TRUNC_BITS >= 0);
  assign a_eff         = i_a;
`endif

  // One extra bit per operand makes a single signed multiply exact for every signedness mix.
  assign a_ext = {i_a_signed & a_eff[A_W-1], a_eff};
  assign b_ext = {i_b_signed & i_b[B_W-1], i_b};
  assign prod  = P_W'(a_ext) * P_W'(b_ext);

  assign adv     = !vld_q[LAT-1] || i_ready;
  assign o_ready = adv;
  assign o_valid = vld_q[LAT-1];
  assign o_mult  = dat_q[LAT-1];

  // Data only loads behind a valid bit, so bubbles leave o_mult at its last product.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < LAT; i++) dat_d[i] = dat_q[i];
    if (adv) begin
      vld_d[0] = i_valid;
      if (i_valid) dat_d[0] = prod;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Self-checking bench for mult_pipe_hs: directed vector table on the default build plus
// backpressure, mid-stream reset and LAT=1 / LAT=4 corner instances with a scoreboard.
module tb_mult_pipe_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // main instance: A_W=B_W=8, LAT=2
  logic        m_valid, m_oready, m_as, m_bs, m_ap, m_ovalid, m_iready;
  logic [7:0]  m_a, m_b;
  logic [16:0] m_omult;

  mult_pipe_hs #(.A_W(8), .B_W(8), .LAT(2), .TRUNC_BITS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(m_valid), .o_ready(m_oready),
    .i_a(m_a), .i_b(m_b), .i_a_signed(m_as), .i_b_signed(m_bs), .i_approx(m_ap),
    .o_valid(m_ovalid), .i_ready(m_iready), .o_mult(m_omult)
  );

  // corner instances: A_W=12, B_W=6, LAT=1 (index 0) and LAT=4 (index 1)
  logic        c_valid [2];
  logic        c_oready[2];
  logic        c_as    [2];
  logic        c_bs    [2];
  logic        c_ap    [2];
  logic        c_ovalid[2];
  logic        c_iready[2];
  logic [11:0] c_a     [2];
  logic [5:0]  c_b     [2];
  logic [18:0] c_omult [2];
  int          c_lat   [2];

  mult_pipe_hs #(.A_W(12), .B_W(6), .LAT(1), .TRUNC_BITS(2)) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_valid(c_valid[0]), .o_ready(c_oready[0]),
    .i_a(c_a[0]), .i_b(c_b[0]), .i_a_signed(c_as[0]), .i_b_signed(c_bs[0]), .i_approx(c_ap[0]),
    .o_valid(c_ovalid[0]), .i_ready(c_iready[0]), .o_mult(c_omult[0])
  );

  mult_pipe_hs #(.A_W(12), .B_W(6), .LAT(4), .TRUNC_BITS(2)) dut_l4 (
    .i_clk(clk), .i_rst(rst), .i_valid(c_valid[1]), .o_ready(c_oready[1]),
    .i_a(c_a[1]), .i_b(c_b[1]), .i_a_signed(c_as[1]), .i_b_signed(c_bs[1]), .i_approx(c_ap[1]),
    .o_valid(c_ovalid[1]), .i_ready(c_iready[1]), .o_mult(c_omult[1])
  );

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        a_s;
    logic        b_s;
    logic        ap;
    logic [16:0] expv;
  } vec_t;

  vec_t vecs[9];

  logic [18:0] sbq0[$];
  logic [18:0] sbq1[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] a, input logic [7:0] b,
                              input logic a_s, input logic b_s, input logic ap, input int e);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.a_s = a_s; v.b_s = b_s; v.ap = ap; v.expv = 17'(e);
    return v;
  endfunction

  // independent reference for the 12x6 instances using 64-bit integer arithmetic
  function automatic logic [18:0] ref_c(input logic [11:0] a, input logic [5:0] b,
                                        input logic a_s, input logic b_s, input logic ap);
    longint av, bv;
    logic [11:0] ae;
    ae = a;
`ifdef MULT_APPROX_TRUNC_EN
    if (ap) ae = {a[11:2], 2'b00};
`else
    if (ap) ae = a;
`endif
    av = a_s ? longint'($signed(ae)) : longint'(ae);
    bv = b_s ? longint'($signed(b))  : longint'(b);
    return 19'(av * bv);
  endfunction

  task automatic sb_push(input int k, input logic [18:0] v);
    if (k == 0) sbq0.push_back(v); else sbq1.push_back(v);
  endtask

  task automatic sb_pop_check(input int k, input logic [18:0] act);
    logic [18:0] e;
    if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
      check(k == 0 ? "l1_sb_extra" : "l4_sb_extra", 1, 0);
    end else begin
      e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
      check(k == 0 ? "l1_sb_data" : "l4_sb_data", act, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, got, stalls, first_seen[2];
    logic stalled_prev, c_hold[2], c_stall[2];
    logic [16:0] held;
    logic [18:0] c_held[2];
    logic [18:0] first_exp[2];

    c_lat[0] = 1; c_lat[1] = 4;

    vecs[0] = mk("u255_x_s-128",   8'd255, 8'h80, 1'b0, 1'b1, 1'b0, -32640);
    vecs[1] = mk("u255_x_u255",    8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 65025);
    vecs[2] = mk("s-1_x_s-128",    8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 128);
    vecs[3] = mk("s-128_x_s-128",  8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 16384);
    vecs[4] = mk("s-1_x_u255",     8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, -255);
`ifdef MULT_APPROX_TRUNC_EN
    vecs[5] = mk("approx_on",      8'd255, 8'd3, 1'b0, 1'b0, 1'b1, 756);
`else
    vecs[5] = mk("approx_ignored", 8'd255, 8'd3, 1'b0, 1'b0, 1'b1, 765);
`endif
    vecs[6] = mk("approx_off",     8'd255, 8'd3, 1'b0, 1'b0, 1'b0, 765);
    vecs[7] = mk("s127_x_s127",    8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, 16129);
    vecs[8] = mk("u128_x_s-128",   8'h80, 8'h80, 1'b0, 1'b1, 1'b0, -16384);

    rst = 1'b1;
    m_valid = 0; m_a = 0; m_b = 0; m_as = 0; m_bs = 0; m_ap = 0; m_iready = 1;
    for (int k = 0; k < 2; k++) begin
      c_valid[k] = 0; c_a[k] = 0; c_b[k] = 0; c_as[k] = 0; c_bs[k] = 0; c_ap[k] = 0;
      c_iready[k] = 1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_o_valid", m_ovalid, 0);
    check("rst_o_mult",  m_omult, 0);
    check("rst_o_ready", m_oready, 1);
    check("rst_l4_valid", c_ovalid[1], 0);
    check("rst_l4_mult",  c_omult[1], 0);

    // directed vector table: single transaction each, i_ready held high
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      m_valid = 1; m_a = vecs[v].a; m_b = vecs[v].b;
      m_as = vecs[v].a_s; m_bs = vecs[v].b_s; m_ap = vecs[v].ap;
      @(negedge clk);
      m_valid = 0;
      check({vecs[v].name, "_early"}, m_ovalid, 0);
      @(negedge clk);
      check({vecs[v].name, "_valid"}, m_ovalid, 1);
      check({vecs[v].name, "_mult"},  m_omult, vecs[v].expv);
      @(negedge clk);
      check({vecs[v].name, "_once"},  m_ovalid, 0);
      check({vecs[v].name, "_held"},  m_omult, vecs[v].expv);
    end

    // backpressure: a=1..5, b=3, i_ready low in cycles 3..5
    idx = 0; got = 0; stalls = 0; stalled_prev = 0; held = 0;
    m_as = 0; m_bs = 0; m_ap = 0; m_b = 8'd3;
    @(negedge clk);
    for (int c = 0; c < 30 && got < 5; c++) begin
      m_iready = !(c >= 3 && c <= 5);
      m_valid  = (idx < 5);
      m_a      = 8'(idx + 1);
      #1;
      check("bp_ready", m_oready, !(m_ovalid && !m_iready));
      if (stalled_prev) begin
        check("bp_hold_valid", m_ovalid, 1);
        check("bp_hold_mult",  m_omult, held);
      end
      if (m_ovalid && m_iready) begin
        check("bp_out", m_omult, 17'(3 * (got + 1)));
        got++;
      end
      if (m_ovalid && !m_iready) stalls++;
      stalled_prev = m_ovalid && !m_iready;
      held = m_omult;
      if (m_valid && m_oready) idx++;
      @(negedge clk);
    end
    m_valid = 0; m_iready = 1;
    check("bp_count",  got, 5);
    check("bp_stalls", stalls, 3);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_dup", m_ovalid, 0);
    end

    // reset with two transactions in flight
    @(negedge clk);
    m_valid = 1; m_a = 8'd7; m_b = 8'd9;
    @(negedge clk);
    m_a = 8'd11; m_b = 8'd13;
    @(negedge clk);
    m_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("mid_rst_valid", m_ovalid, 0);
    check("mid_rst_mult",  m_omult, 0);
    check("mid_rst_ready", m_oready, 1);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_quiet", m_ovalid, 0);
    end

    // corner instances: first-output latency
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      c_valid[k] = 1; c_a[k] = 12'hA5C; c_b[k] = 6'h2B; c_as[k] = 1; c_bs[k] = 1;
      c_ap[k] = 0; c_iready[k] = 1; first_seen[k] = -1;
      first_exp[k] = ref_c(12'hA5C, 6'h2B, 1'b1, 1'b1, 1'b0);
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        c_valid[k] = 0;
        if (c_ovalid[k] && first_seen[k] < 0) begin
          first_seen[k] = cyc;
          check(k == 0 ? "l1_first_mult" : "l4_first_mult", c_omult[k], first_exp[k]);
        end
      end
    end
    check("l1_latency", first_seen[0], c_lat[0]);
    check("l4_latency", first_seen[1], c_lat[1]);

    // corner instances: random traffic against the scoreboard
    for (int k = 0; k < 2; k++) begin c_hold[k] = 0; c_stall[k] = 0; c_held[k] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!c_hold[k]) begin
          c_valid[k] = ($urandom_range(0, 9) < 7);
          c_a[k]  = 12'($urandom);
          c_b[k]  = 6'($urandom);
          c_as[k] = 1'($urandom);
          c_bs[k] = 1'($urandom);
          c_ap[k] = 1'($urandom);
        end
        c_iready[k] = ($urandom_range(0, 9) < 6);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (c_stall[k]) begin
          check(k == 0 ? "l1_hold_valid" : "l4_hold_valid", c_ovalid[k], 1);
          check(k == 0 ? "l1_hold_mult"  : "l4_hold_mult",  c_omult[k], c_held[k]);
        end
        if (c_ovalid[k] && c_iready[k]) sb_pop_check(k, c_omult[k]);
        c_stall[k] = c_ovalid[k] && !c_iready[k];
        c_held[k]  = c_omult[k];
        if (c_valid[k] && c_oready[k]) begin
          sb_push(k, ref_c(c_a[k], c_b[k], c_as[k], c_bs[k], c_ap[k]));
          c_hold[k] = 0;
        end else begin
          c_hold[k] = c_valid[k];
        end
      end
      @(negedge clk);
    end
    // drain: stop issuing, accept everything
    for (int k = 0; k < 2; k++) begin c_iready[k] = 1; end
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!c_hold[k]) c_valid[k] = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (c_ovalid[k]) sb_pop_check(k, c_omult[k]);
        if (c_valid[k] && c_oready[k]) begin
          sb_push(k, ref_c(c_a[k], c_b[k], c_as[k], c_bs[k], c_ap[k]));
          c_hold[k] = 0;
        end
      end
      @(negedge clk);
    end
    check("l1_sb_drained", sbq0.size(), 0);
    check("l4_sb_drained", sbq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe_hs.md
Name: mult_pipe_hs

Overview:
- Parametrised, pipelined successor to the team's 8x8 unsigned-by-signed multiplier.
- Per-transaction signedness select for each operand; LAT-stage registered pipeline.
- valid/ready handshake on both sides with full-throughput backpressure.
- Feeds the HPF filter tap datapath, where taps arrive in bursts and the accumulator can stall.

Parameters:
A_W, 8, operand A width in bits (2..32)
B_W, 8, operand B width in bits (2..32)
LAT, 2, pipeline depth in cycles from accepted input to o_valid (1..4)
TRUNC_BITS, 2, LSBs of A zeroed in approximate mode (0..A_W-1; used only with the macro)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input transaction valid
o_ready  output  1  block can accept input this cycle
i_a  input  A_W  operand A
i_b  input  B_W  operand B
i_a_signed  input  1  1: i_a two's complement; 0: unsigned
i_b_signed  input  1  1: i_b two's complement; 0: unsigned
i_approx  input  1  1: approximate product for this transaction (ignored if macro absent)
o_valid  output  1  o_mult holds a valid product
i_ready  input  1  downstream accepts o_mult this cycle
o_mult  output  A_W+B_W+1  signed product (P_W)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high.
- Reset values:
  - All stage valid bits = 0, so o_valid = 0.
  - o_mult = 0 and all data stage registers = 0.
  - o_ready = 1 in the first cycle after i_rst deasserts.
- Advance condition: adv = !o_valid || i_ready. o_ready = adv, combinational; no combinational path i_valid -> o_ready.
- Transfers:
  - Input accepted when i_valid && o_ready.
  - Output consumed when o_valid && i_ready.
- Stall: when adv = 1, every stage shifts one position; stage 0 captures the input and its valid bit = i_valid. When adv = 0, all stages hold data and valid bits, so o_mult stays stable while o_valid && !i_ready.
- Bubbles: a stage with valid = 0 is a bubble, and bubbles are shifted out normally. adv is global; bubbles are not collapsed.
- Latency and throughput:
  - With i_ready held at 1, a product accepted in cycle N appears with o_valid = 1 in cycle N+LAT.
  - Throughput is 1 product per cycle.
- Arithmetic:
  - Each operand is extended by 1 bit: sign bit if its _signed flag is 1, else 0.
  - The (A_W+1) x (B_W+1) signed product is truncated to P_W = A_W+B_W+1 bits. This is exact for all four signedness combinations.
  - The multiply is computed in stage 0. Remaining stages are pure register stages, and retiming is permitted. When LAT = 1, stage 0 is the output register.
- Mode bits i_a_signed, i_b_signed and i_approx are sampled with the operands and apply only to that transaction.
- Simultaneous events:
  - Input accept and output consume in the same cycle is legal, and the pipeline stays full.
  - i_valid while o_ready = 0: the input is not captured, and the upstream holds it.
- Reset mid-operation: all in-flight transactions are discarded. No partial output is ever presented after reset.
- Data fields of stages with valid = 0 are don't-care internally, but o_mult is held at its last valid value, or 0 after reset.

Optional Feature:
Macro: MULT_APPROX_TRUNC_EN
- Defined:
  - When the sampled i_approx = 1, the TRUNC_BITS LSBs of i_a are forced to 0 before extension and multiply. This is the approximate-computing mode for filter taps.
  - When i_approx = 0, the product is exact.
- Undefined:
  - i_approx is ignored and the product is always exact.
  - No truncation logic is synthesised; the port remains present for interface stability.

Test Plan:
1. Reset, LAT=2, A_W=B_W=8: i_a=255 (unsigned), i_b=-128 (signed), i_valid pulse in cycle 0, i_ready=1 -> o_valid=1 in cycle 2 only, o_mult=-32640 (17'h18080).
2. Signedness sweep, same parameters: 255x255 with both unsigned -> 65025; i_a=8'hFF signed, i_b=-128 signed -> 128; i_a=-128 signed, i_b=-128 signed -> 16384; -1 signed x 255 unsigned -> -255.
3. Backpressure: stream 5 back-to-back inputs a=1..5, b=3 unsigned, with i_ready=0 in cycles 3-5 -> o_ready=0 exactly while o_valid && !i_ready; o_mult held stable; outputs 3,6,9,12,15 in order, none lost or duplicated.
4. Reset mid-stream: 2 transactions in flight, assert i_rst for 1 cycle -> o_valid=0 and o_mult=0 the next cycle; no product emerges in the following LAT cycles.
5. Approx mode with macro defined, TRUNC_BITS=2: a=255 unsigned, b=3 unsigned, i_approx=1 -> 756; same with i_approx=0 -> 765. With macro undefined, i_approx=1 -> 765.
6. Parameter corners: LAT=1 and LAT=4, A_W=12, B_W=6, random operands and modes, random i_valid/i_ready -> every output equals the scoreboard reference; first-output latency equals LAT.
